// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial add/subtract sequencer around one shared 1-bit full adder.
//
// Operands are latched on an accepted start, then fed LSB-first through the single fulladder
// instance, one bit per clock, with a carry flop chaining the steps. On the final bit the sum,
// carry/no-borrow and signed-overflow flags are registered and done pulses for one cycle.
//
// Ports:
//   clk   - rising-edge clock
//   rst   - asynchronous active-high reset
//   start - begin an operation (accepted in IDLE or DONE)
//   sub   - 0: a + b + cin, 1: a - b (sampled with start)
//   cin   - carry-in for add mode, ignored when subtracting
//   a, b  - WIDTH-bit operands (sampled with start)
//   busy  - operation in progress
//   done  - one-cycle pulse, result outputs just updated
//   sum   - result, held until the next completion
//   cout  - final carry; in sub mode 1 = no borrow
//   ovf   - two's-complement overflow of the last operation

module fulladder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_add_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] sa_q;
    logic [WIDTH-1:0] sb_q;
    logic [WIDTH-1:0] sr_q;
    logic             c_q;
    logic [CntW-1:0]  cnt_q;

    logic fa_s;
    logic fa_co;

    fulladder u_fa (
        .a  (sa_q[0]),
        .b  (sb_q[0]),
        .ci (c_q),
        .s  (fa_s),
        .co (fa_co)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            sa_q    <= '0;
            sb_q    <= '0;
            sr_q    <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            sum     <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        // Subtract as a + ~b + 1.
                        sa_q    <= a;
                        sb_q    <= sub ? ~b : b;
                        c_q     <= sub ? 1'b1 : cin;
                        cnt_q   <= '0;
                        state_q <= StRun;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StRun: begin
                    sr_q  <= {fa_s, sr_q[WIDTH-1:1]};
                    c_q   <= fa_co;
                    sa_q  <= {1'b0, sa_q[WIDTH-1:1]};
                    sb_q  <= {1'b0, sb_q[WIDTH-1:1]};
                    cnt_q <= cnt_q + CntW'(1);
                    if (cnt_q == LastCnt) begin
                        sum     <= {fa_s, sr_q[WIDTH-1:1]};
                        cout    <= fa_co;
                        // Carry into the MSB differs from carry out of it on signed overflow.
                        ovf     <= c_q ^ fa_co;
                        state_q <= StDone;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy = (state_q == StRun);
    assign done = (state_q == StDone);

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl: an 8-bit instance for directed and control cases and a
// 2-bit instance for exhaustive checking against a reference model.
module tb_serial_add_ctrl;

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        int          start_cyc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endfunction

    // 8-bit instance
    logic       rst8 = 1'b1, start8 = 1'b0, sub8 = 1'b0, cin8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0, sum8;
    logic       busy8, done8, cout8, ovf8;

    serial_add_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst8), .start(start8), .sub(sub8), .cin(cin8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
    );

    // 2-bit instance
    logic       rst2 = 1'b1, start2 = 1'b0, sub2 = 1'b0, cin2 = 1'b0;
    logic [1:0] a2 = '0, b2 = '0, sum2;
    logic       busy2, done2, cout2, ovf2;

    serial_add_ctrl #(.WIDTH(2)) dut2 (
        .clk(clk), .rst(rst2), .start(start2), .sub(sub2), .cin(cin2), .a(a2), .b(b2),
        .busy(busy2), .done(done2), .sum(sum2), .cout(cout2), .ovf(ovf2)
    );

    exp_t q8[$];
    exp_t q2[$];

    // Monitors: pop and compare whenever done is seen.
    always @(negedge clk) begin
        if (done8) begin
            if (q8.size() == 0) begin
                chk("w8_unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q8.pop_front();
                chk("w8_sum", {24'd0, sum8}, e.sum);
                chk("w8_cout", {31'd0, cout8}, {31'd0, e.cout});
                chk("w8_ovf", {31'd0, ovf8}, {31'd0, e.ovf});
                chk("w8_latency", cyc - e.start_cyc, 32'd8);
                chk("w8_busy_with_done", {31'd0, busy8}, 32'd0);
            end
        end
    end

    always @(negedge clk) begin
        if (done2) begin
            if (q2.size() == 0) begin
                chk("w2_unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q2.pop_front();
                chk("w2_sum", {30'd0, sum2}, e.sum);
                chk("w2_cout", {31'd0, cout2}, {31'd0, e.cout});
                chk("w2_ovf", {31'd0, ovf2}, {31'd0, e.ovf});
                chk("w2_latency", cyc - e.start_cyc, 32'd2);
            end
        end
    end

    task automatic push8(input logic [7:0] es, input logic ec, input logic eo);
        exp_t e;
        e.sum = {24'd0, es};
        e.cout = ec;
        e.ovf = eo;
        e.start_cyc = cyc + 1;
        q8.push_back(e);
    endtask

    task automatic drain8();
        for (int i = 0; i < 40; i++) begin
            if (q8.size() == 0) break;
            @(negedge clk);
        end
        if (q8.size() != 0) begin
            chk("w8_done_timeout", q8.size(), 32'd0);
            q8.delete();
        end
        @(negedge clk);
    endtask

    task automatic op8(input logic [7:0] ta, input logic [7:0] tb, input logic tcin,
                       input logic tsub, input logic [7:0] es, input logic ec, input logic eo);
        @(negedge clk);
        a8 = ta; b8 = tb; cin8 = tcin; sub8 = tsub; start8 = 1'b1;
        push8(es, ec, eo);
        @(negedge clk);
        start8 = 1'b0;
        a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0;
        drain8();
    endtask

    task automatic op2(input logic [1:0] ta, input logic [1:0] tb, input logic tcin,
                       input logic tsub);
        exp_t e;
        logic [1:0] bb;
        logic       ci;
        logic [2:0] t;
        bb = tsub ? ~tb : tb;
        ci = tsub ? 1'b1 : tcin;
        t = {1'b0, ta} + {1'b0, bb} + {2'b0, ci};
        @(negedge clk);
        a2 = ta; b2 = tb; cin2 = tcin; sub2 = tsub; start2 = 1'b1;
        e.sum = {30'd0, t[1:0]};
        e.cout = t[2];
        e.ovf = (ta[1] == bb[1]) && (t[1] != ta[1]);
        e.start_cyc = cyc + 1;
        q2.push_back(e);
        @(negedge clk);
        start2 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (q2.size() == 0) break;
            @(negedge clk);
        end
        if (q2.size() != 0) begin
            chk("w2_done_timeout", q2.size(), 32'd0);
            q2.delete();
        end
    endtask

    initial begin
        // Reset, then idle for 20 cycles with everything at zero.
        repeat (2) @(negedge clk);
        rst8 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("reset_idle", {20'd0, busy8, done8, cout8, ovf8, sum8}, 32'd0);
        end

        // Directed add/sub.
        op8(8'h3C, 8'h55, 1'b0, 1'b0, 8'h91, 1'b0, 1'b1);
        op8(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        op8(8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0);
        op8(8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0);
        op8(8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);

        // start pulsed mid-RUN is ignored.
        @(negedge clk);
        a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; sub8 = 1'b0; start8 = 1'b1;
        push8(8'h46, 1'b0, 1'b0);
        @(negedge clk);
        start8 = 1'b0;
        repeat (2) @(negedge clk);
        a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        drain8();
        repeat (15) @(negedge clk);

        // start held high: back-to-back, each result from its own operands.
        @(negedge clk);
        a8 = 8'h40; b8 = 8'h20; cin8 = 1'b0; sub8 = 1'b1; start8 = 1'b1;
        push8(8'h20, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done8) break;
        end
        a8 = 8'h7F; b8 = 8'h01; cin8 = 1'b0; sub8 = 1'b0;
        push8(8'h80, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done8) break;
        end
        a8 = 8'hA5; b8 = 8'h5A; cin8 = 1'b1; sub8 = 1'b1;
        push8(8'h4B, 1'b1, 1'b1);
        @(negedge clk);
        start8 = 1'b0;
        drain8();

        // Reset during the 4th RUN cycle aborts with no done.
        @(negedge clk);
        a8 = 8'hAA; b8 = 8'h11; cin8 = 1'b0; sub8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        rst8 = 1'b1;
        #1;
        chk("mid_run_reset", {20'd0, busy8, done8, cout8, ovf8, sum8}, 32'd0);
        @(negedge clk);
        rst8 = 1'b0;
        repeat (15) @(negedge clk);
        chk("after_reset_idle", {20'd0, busy8, done8, cout8, ovf8, sum8}, 32'd0);

        // Operation after the abort completes normally.
        op8(8'hA5, 8'h5A, 1'b0, 1'b1, 8'h4B, 1'b1, 1'b1);

        // WIDTH=2 exhaustive.
        @(negedge clk);
        rst2 = 1'b0;
        for (int s = 0; s < 2; s++)
            for (int ci = 0; ci < 2; ci++)
                for (int x = 0; x < 4; x++)
                    for (int y = 0; y < 4; y++)
                        op2(2'(x), 2'(y), 1'(ci), 1'(s));

        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Bit-serial add/subtract sequencer built around a single `fulladder` instance. It latches two WIDTH-bit operands on a start request, then steps them LSB-first through the one full adder, one bit per clock. A carry flip-flop links each step to the next. When the last bit is done it presents the sum, carry/no-borrow and signed-overflow flags with a one-cycle done pulse. It is the scheduling front end that lets the shared 1-bit adder datapath serve arbitrary-width arithmetic.

## Interface
Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock; the single clock of the block.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  request to begin an operation; sampled on clk rising edge.
- sub  input  1  0 = add (a + b + cin), 1 = subtract (a - b); sampled with start.
- cin  input  1  carry-in for add mode; sampled with start; ignored when sub = 1.
- a  input  WIDTH  operand A; sampled with start.
- b  input  WIDTH  operand B; sampled with start.
- busy  output  1  high while an operation is in progress (RUN state).
- done  output  1  one-cycle pulse: result outputs were just updated.
- sum  output  WIDTH  result; holds its value until the next completion.
- cout  output  1  final carry; in sub mode, 1 = no borrow (a >= b unsigned).
- ovf  output  1  two's-complement signed overflow of the last operation.

## Operation
- Exactly one `fulladder` instance performs all arithmetic. No other adder or `+` operator on the operand path.
- Internal state: operand shift regs sa/sb (WIDTH), result shift reg sr (WIDTH), carry reg c, bit counter cnt (ceil(log2(WIDTH)) bits), state in {IDLE, RUN, DONE}.
- Start acceptance, in IDLE or DONE with start = 1:
  - sa <= a; sb <= sub ? ~b : b; c <= sub ? 1 : cin.
  - cnt <= 0; state <= RUN.
- RUN, each cycle:
  - Adder inputs are sa[0], sb[0], c.
  - sr <= {s, sr[WIDTH-1:1]}; c <= cout_fa; sa, sb shift right by 1; cnt <= cnt + 1.
  - On the step where cnt = WIDTH-1 the final bit is processed:
    - sum <= {s, sr[WIDTH-1:1]}; cout <= cout_fa.
    - ovf <= c XOR cout_fa, where c is the carry into the MSB.
    - state <= DONE.
- DONE lasts exactly one cycle, then returns to IDLE. If start = 1 in that cycle, it goes directly to RUN with new operands (back-to-back).
- start in RUN is ignored: no queueing and no effect on the operation in flight.
- Results are modulo 2^WIDTH. sum, cout and ovf change only on the final RUN step.
- Outputs:
  - busy = (state == RUN).
  - done = (state == DONE).

## Timing
- Reset values: state IDLE, busy 0, done 0, sum 0, cout 0, ovf 0, c 0, cnt 0, sa/sb/sr 0.
- Assertion of rst at any time, including mid-RUN, aborts immediately to the reset values. Partial results are discarded.
- Latency: start sampled at edge E0 → busy = 1 from E0 through E(WIDTH).
  - Result registered at E(WIDTH); done = 1 between E(WIDTH) and E(WIDTH+1).
  - Start-to-done is WIDTH+1 edges.
- Throughput: with start held high, a new operation starts every WIDTH+1 cycles.
- busy and done are never high together.
- a, b, sub and cin may change freely after the accepting edge.

## Test plan
- Reset, no start for 20 cycles → busy = 0, done = 0, sum = 0x00, cout = 0, ovf = 0 throughout.
- WIDTH = 8, add:
  - a = 0x3C, b = 0x55, cin = 0 → done exactly 9 edges after start; sum = 0x91, cout = 0, ovf = 1.
  - a = 0xFF, b = 0x01, cin = 0 → sum = 0x00, cout = 1, ovf = 0.
  - a = 0x00, b = 0x00, cin = 1 → sum = 0x01.
- WIDTH = 8, subtract:
  - a = 0x05, b = 0x07, cin = 1 → sum = 0xFE, cout = 0, ovf = 0 (cin ignored).
  - a = 0x80, b = 0x01 → sum = 0x7F, cout = 1, ovf = 1.
- Control:
  - Pulse start mid-RUN with different operands → first result unaffected; no extra done pulse.
  - start held high → done pulses every 9 cycles; each result matches the operands sampled at its own acceptance.
  - Assert rst at the 4th RUN cycle → all outputs 0 immediately; no done pulse.
  - A following start completes correctly.
- WIDTH = 2, exhaustive: all a, b, cin, sub combinations (64 operations) checked against a reference model for sum, cout and ovf.
